// File: rtl/pa_spsram_mbist_ctrl_pkg.sv
// Purpose: shared types and March C- tables for the single-port SRAM BIST controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Optional feature: PA_MBIST_WEN_TEST_EN adds the WENT state (per-lane write-enable test).
package pa_mbist_pkg;

`ifdef PA_MBIST_WEN_TEST_EN
    typedef enum logic [2:0] {ST_IDLE, ST_MARCH, ST_WENT, ST_DRAIN, ST_DONE} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_MARCH, ST_DRAIN, ST_DONE} state_t;
`endif

    typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_t;

    localparam logic [2:0] ELEM_W0_UP   = 3'd0;
    localparam logic [2:0] ELEM_R0W1_UP = 3'd1;
    localparam logic [2:0] ELEM_R1W0_UP = 3'd2;
    localparam logic [2:0] ELEM_R0W1_DN = 3'd3;
    localparam logic [2:0] ELEM_R1W0_DN = 3'd4;
    localparam logic [2:0] ELEM_R0_UP   = 3'd5;
    localparam logic [2:0] ELEM_WENT    = 3'd6;

    // Indexed by element code: 1 = element walks addresses downwards.
    localparam logic [7:0] ELEM_IS_DOWN = 8'b0001_1000;
    // Indexed by element code: 1 = element does a read then a write per address.
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;

    // Operation of an element; 'second' selects the second op of a two-op element.
    function automatic op_t elem_op(input logic [2:0] elem, input logic second);
        case (elem)
            ELEM_W0_UP:                 elem_op = OP_W0;
            ELEM_R0W1_UP, ELEM_R0W1_DN: elem_op = second ? OP_W1 : OP_R0;
            ELEM_R1W0_UP, ELEM_R1W0_DN: elem_op = second ? OP_W0 : OP_R1;
            default:                    elem_op = OP_R0;
        endcase
    endfunction

endpackage

// File: rtl/pa_spsram_mbist_ctrl_if.sv
// Purpose: SRAM port bundle between the BIST controller (master) and the array (slave).
// Latency: n/a (wires only); mem_q is valid the cycle after a read.
// Backpressure: none; the SRAM accepts one operation per cycle.
// Signals: mem_a address, mem_cen/mem_gwen/mem_wen active-low enables, mem_d write data, mem_q read data.
interface pa_spsram_mbist_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16,
    parameter int WE_WIDTH   = 16
);
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_cen;
    logic                  mem_gwen;
    logic [WE_WIDTH-1:0]   mem_wen;
    logic [DATA_WIDTH-1:0] mem_d;
    logic [DATA_WIDTH-1:0] mem_q;

    modport master (output mem_a, mem_cen, mem_gwen, mem_wen, mem_d, input mem_q);
    modport slave  (input mem_a, mem_cen, mem_gwen, mem_wen, mem_d, output mem_q);
endinterface

// File: rtl/pa_spsram_mbist_ctrl_addr_gen.sv
// Purpose: up/down address counter for March elements, with terminal-address flag.
// Latency: load/step take effect at the next clock edge; last is combinational from the count.
// Backpressure: none; step advances unconditionally.
// Ports: forever_cpuclk, cpurst_b, load (reload for dir), dir (1 = down), step, addr, last.
module pa_mbist_addr_gen #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  load,
    input  logic                  dir,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    import pa_mbist_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic dir_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            addr  <= '0;
            dir_q <= 1'b0;
        end else if (load) begin
            addr  <= dir ? '1 : '0;
            dir_q <= dir;
        end else if (step) begin
            addr <= dir_q ? addr - ONE : addr + ONE;
        end
    end

    assign last = dir_q ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/pa_spsram_mbist_ctrl.sv
// Purpose: March C- BIST controller for one pa_spsram_* single-port SRAM; logs first miscompare.
// Latency: first SRAM access the cycle after start; 10N ops + 1 drain cycle until done.
// Backpressure: none; start is ignored while busy, done holds until the next accepted start.
// Ports: forever_cpuclk/cpurst_b, mbist_start, mbist_busy/done/pass, mbist_fail_addr/elem/bits,
//        sram (master side of pa_spsram_mbist_ctrl_if, all outputs registered).
// Optional feature: define PA_MBIST_WEN_TEST_EN to append the per-lane WEN test (element 6).
module pa_spsram_mbist_ctrl
    import pa_mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16,
    parameter int WE_WIDTH   = 16
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic                   mbist_start,
    output logic                   mbist_busy,
    output logic                   mbist_done,
    output logic                   mbist_pass,
    output logic [ADDR_WIDTH-1:0]  mbist_fail_addr,
    output logic [2:0]             mbist_fail_elem,
    output logic [DATA_WIDTH-1:0]  mbist_fail_bits,
    pa_spsram_mbist_ctrl_if.master sram
);

`ifdef PA_MBIST_WEN_TEST_EN
    localparam int LANE_W = DATA_WIDTH / WE_WIDTH;
    localparam int WIDX_W = $clog2(2 * WE_WIDTH + 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(2 * WE_WIDTH);
    logic [WIDX_W-1:0] widx, nxt_widx;
    int                went_lane;
`endif

    state_t                state, nxt_state;
    logic [2:0]            elem, nxt_elem, elem_inc;
    logic                  phase, nxt_phase;
    logic                  ag_load, ag_dir, ag_step, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;

    // Operation to present in the next cycle.
    logic                  op_cen, op_gwen, op_rd;
    logic [WE_WIDTH-1:0]   op_wen;
    logic [DATA_WIDTH-1:0] op_d, op_exp;

    // Operation currently on the SRAM pins.
    logic                  cen_q, gwen_q, rd_q;
    logic [WE_WIDTH-1:0]   wen_q;
    logic [DATA_WIDTH-1:0] d_q, exp_q;

    // Compare stage: the read issued last cycle, checked against mem_q now.
    logic                  cmp_vld;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [2:0]            cmp_elem;
    logic [DATA_WIDTH-1:0] cmp_xor;
    logic                  miscmp, fail_q, start_acc;

    pa_mbist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .load           (ag_load),
        .dir            (ag_dir),
        .step           (ag_step),
        .addr           (ag_addr),
        .last           (ag_last)
    );

    assign start_acc = mbist_start && (state == ST_IDLE || state == ST_DONE);
    assign cmp_xor   = sram.mem_q ^ cmp_exp;
    assign miscmp    = cmp_vld && (|cmp_xor);

    always_comb begin
        nxt_state = state;
        nxt_elem  = elem;
        nxt_phase = phase;
        elem_inc  = elem + 3'd1;
        ag_load   = 1'b0;
        ag_dir    = 1'b0;
        ag_step   = 1'b0;
`ifdef PA_MBIST_WEN_TEST_EN
        nxt_widx  = widx;
        went_lane = 0;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (mbist_start) begin
                    nxt_state = ST_MARCH;
                    nxt_elem  = ELEM_W0_UP;
                    nxt_phase = 1'b0;
                    ag_load   = 1'b1;
                end
            end
            ST_MARCH: begin
                if (ELEM_TWO_OPS[elem] && !phase) begin
                    nxt_phase = 1'b1;
                end else if (!ag_last) begin
                    nxt_phase = 1'b0;
                    ag_step   = 1'b1;
                end else if (elem != ELEM_R0_UP) begin
                    // Reload for the next element's direction with no bubble.
                    nxt_elem  = elem_inc;
                    nxt_phase = 1'b0;
                    ag_load   = 1'b1;
                    ag_dir    = ELEM_IS_DOWN[elem_inc];
                end else begin
`ifdef PA_MBIST_WEN_TEST_EN
                    nxt_state = ST_WENT;
                    nxt_elem  = ELEM_WENT;
                    nxt_widx  = '0;
                    ag_load   = 1'b1;
`else
                    nxt_state = ST_DRAIN;
`endif
                end
            end
`ifdef PA_MBIST_WEN_TEST_EN
            ST_WENT: begin
                if (widx == WIDX_LAST) nxt_state = ST_DRAIN;
                else                   nxt_widx  = widx + 1'b1;
            end
`endif
            ST_DRAIN: nxt_state = ST_DONE;
            default:  nxt_state = ST_IDLE;
        endcase

        op_cen  = 1'b1;
        op_gwen = 1'b1;
        op_wen  = '1;
        op_d    = '0;
        op_rd   = 1'b0;
        op_exp  = '0;
        if (nxt_state == ST_MARCH) begin
            op_cen = 1'b0;
            case (elem_op(nxt_elem, nxt_phase))
                OP_W0: begin op_gwen = 1'b0; op_wen = '0; end
                OP_W1: begin op_gwen = 1'b0; op_wen = '0; op_d = '1; end
                OP_R0: op_rd = 1'b1;
                OP_R1: begin op_rd = 1'b1; op_exp = '1; end
                default: op_cen = 1'b1;
            endcase
        end
`ifdef PA_MBIST_WEN_TEST_EN
        else if (nxt_state == ST_WENT) begin
            // Step 0 clears the word; odd steps write ones through one lane, even steps read back.
            op_cen    = 1'b0;
            went_lane = (int'(nxt_widx) - 1) / 2;
            if (nxt_widx == '0) begin
                op_gwen = 1'b0;
                op_wen  = '0;
            end else if (nxt_widx[0]) begin
                op_gwen = 1'b0;
                op_wen  = ~(WE_WIDTH'(1) << went_lane);
                op_d    = '1;
            end else begin
                op_rd = 1'b1;
                for (int j = 0; j < WE_WIDTH; j++) begin
                    if (j <= went_lane) op_exp[j*LANE_W +: LANE_W] = '1;
                end
            end
        end
`endif
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state           <= ST_IDLE;
            elem            <= '0;
            phase           <= 1'b0;
`ifdef PA_MBIST_WEN_TEST_EN
            widx            <= '0;
`endif
            cen_q           <= 1'b1;
            gwen_q          <= 1'b1;
            wen_q           <= '1;
            d_q             <= '0;
            rd_q            <= 1'b0;
            exp_q           <= '0;
            cmp_vld         <= 1'b0;
            cmp_exp         <= '0;
            cmp_addr        <= '0;
            cmp_elem        <= '0;
            fail_q          <= 1'b0;
            mbist_busy      <= 1'b0;
            mbist_done      <= 1'b0;
            mbist_pass      <= 1'b0;
            mbist_fail_addr <= '0;
            mbist_fail_elem <= '0;
            mbist_fail_bits <= '0;
        end else begin
            state    <= nxt_state;
            elem     <= nxt_elem;
            phase    <= nxt_phase;
`ifdef PA_MBIST_WEN_TEST_EN
            widx     <= nxt_widx;
`endif
            cen_q    <= op_cen;
            gwen_q   <= op_gwen;
            wen_q    <= op_wen;
            d_q      <= op_d;
            rd_q     <= op_rd;
            exp_q    <= op_exp;
            cmp_vld  <= rd_q;
            cmp_exp  <= exp_q;
            cmp_addr <= ag_addr;
            cmp_elem <= elem;

            if (start_acc) begin
                mbist_busy      <= 1'b1;
                mbist_done      <= 1'b0;
                mbist_pass      <= 1'b0;
                fail_q          <= 1'b0;
                mbist_fail_addr <= '0;
                mbist_fail_elem <= '0;
                mbist_fail_bits <= '0;
            end else if (miscmp && !fail_q) begin
                fail_q          <= 1'b1;
                mbist_fail_addr <= cmp_addr;
                mbist_fail_elem <= cmp_elem;
                mbist_fail_bits <= cmp_xor;
            end

            // The drain cycle holds the final compare, so fold it into pass directly.
            if (state == ST_DRAIN) begin
                mbist_busy <= 1'b0;
                mbist_done <= 1'b1;
                mbist_pass <= !(fail_q || miscmp);
            end
        end
    end

    assign sram.mem_a    = ag_addr;
    assign sram.mem_cen  = cen_q;
    assign sram.mem_gwen = gwen_q;
    assign sram.mem_wen  = wen_q;
    assign sram.mem_d    = d_q;

endmodule
